// File: rtl/ifetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory port and decode handshake.
interface ifetch_if;
    localparam int unsigned XLEN = 32;

    // Redirect from next-PC logic
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    // Instruction memory read port
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    // Decode handshake
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] inst_pc;

    // Fetch stage side
    modport master (
        input  redirect, redirect_pc,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  inst_ready,
        output imem_req, imem_addr,
        output inst_valid, inst, inst_pc
    );

    // Environment side (next-PC logic, memory, decode)
    modport slave (
        output redirect, redirect_pc,
        output imem_gnt, imem_rvalid, imem_rdata,
        output inst_ready,
        input  imem_req, imem_addr,
        input  inst_valid, inst, inst_pc
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding word read, 2-entry {pc, inst} buffer toward decode,
// redirect flushes the buffer and drops any in-flight response.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic     clk,
    input  logic     rst_n,
    ifetch_if.master bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = 2;

    localparam logic [XLEN-1:0] NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    entry_t          head_q, tail_q;
    logic [CW-1:0]   count_q;

    logic            req_c;
    logic            grant_c;
    logic            push_c;
    logic            pop_c;
    logic [XLEN-1:0] target_c;
    entry_t          push_entry_c;

    // Misaligned redirect targets are truncated to a word boundary
    assign target_c = bus.redirect_pc & ALIGN_MASK;

    // Request only while in REQ and the buffer can take the eventual response
    assign req_c   = (state_q == REQ) && (count_q < CW'(DEPTH));
    assign grant_c = req_c && bus.imem_gnt;

    // A redirect discards the whole buffer, so a same-cycle pop is meaningless
    assign pop_c = (count_q != '0) && bus.inst_ready && !bus.redirect;

    assign push_entry_c = '{pc: pend_pc_q, inst: bus.imem_rdata};

    // FSM state, fetch PC and granted-address register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // Next-state, fetch-PC update and push decision; redirect overrides last
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        push_c     = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (grant_c) begin
                    pend_pc_d  = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + PC_STEP;
                    // An accepted old address must still have its response swallowed
                    state_d    = bus.redirect ? DROP : WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    push_c  = !bus.redirect;
                    state_d = REQ;
                end else if (bus.redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (bus.imem_rvalid) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (bus.redirect) begin
            fetch_pc_d = target_c;
        end
    end

    // Two-entry buffer: head feeds decode directly, tail holds the second entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '{pc: RESET_PC, inst: NOP};
            tail_q  <= '{pc: RESET_PC, inst: NOP};
            count_q <= '0;
        end else if (bus.redirect) begin
            count_q <= '0;
        end else begin
            case ({push_c, pop_c})
                2'b10: begin
                    if (count_q == '0) begin
                        head_q <= push_entry_c;
                    end else begin
                        tail_q <= push_entry_c;
                    end
                    count_q <= count_q + CW'(1);
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - CW'(1);
                end
                2'b11: begin
                    if (count_q == CW'(DEPTH)) begin
                        head_q <= tail_q;
                        tail_q <= push_entry_c;
                    end else begin
                        head_q <= push_entry_c;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs come straight from registers; no path from imem_rdata to decode
    assign bus.imem_req   = req_c;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = (count_q != '0);
    assign bus.inst       = head_q.inst;
    assign bus.inst_pc    = head_q.pc;

endmodule
